// File: rtl/sa_os_array_pkg.sv
// Shared types and helpers for the sa_os_array output-stationary systolic engine.
package sa_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned COLS_DEF  = 8;

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, BIAS, DRAIN} sa_state_e;

  typedef logic signed [DW_DEF-1:0]          elem_t;
  typedef logic signed [ACC_W_DEF-1:0]       acc_t;
  typedef logic        [COLS_DEF*DW_DEF-1:0] vec_t;
  typedef logic signed [63:0]                wide_t;

  // Arithmetic (floor) right shift followed by saturation to a signed width-bit range.
  function automatic wide_t requant(input wide_t acc, input int unsigned shift,
                                    input int unsigned width);
    wide_t shifted;
    wide_t hi;
    wide_t lo;
    wide_t res;
    shifted = acc >>> shift;
    hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo      = -(wide_t'(1) <<< (width - 1));
    if (shifted > hi)      res = hi;
    else if (shifted < lo) res = lo;
    else                   res = shifted;
    return res;
  endfunction

endpackage

// File: rtl/sa_os_array_pe.sv
// Single processing element: registered a/w pass-through and a signed MAC accumulator.
module sa_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         bias_add,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] w_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(w_in);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      w_out <= w_in;
      acc   <= acc + ACC_WIDTH'(prod);
    end else if (bias_add) begin
      acc   <= acc + ACC_WIDTH'(bias);
    end
  end

endmodule

// File: rtl/sa_os_array.sv
// Parametrised output-stationary systolic array: C = A*W (+bias), requantised, streamed per row.
// Optional macro SA_RELU_EN clamps negative requantised outputs to zero.
module sa_os_array
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 8,
  parameter int unsigned K_MAX       = 256,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_vec_i,
  input  logic [COLS*DATA_WIDTH-1:0]    w_vec_i,
  input  logic                          bias_valid_i,
  output logic                          bias_ready_o,
  input  logic [COLS*DATA_WIDTH-1:0]    bias_vec_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [COLS*DATA_WIDTH-1:0]    out_row_o,
  output logic                          out_last_o,
  output logic                          busy_o
);

  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned CW = $clog2(K_MAX + ROWS + COLS + 1);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  sa_state_e               state;
  sa_state_e               next;
  logic [KW-1:0]           k_reg;
  logic [SHIFT_WIDTH-1:0]  shift_reg;
  logic [CW-1:0]           cnt;
  logic [RW-1:0]           row_idx;
  logic                    adv;
  logic                    clr;
  logic                    bias_add;
  logic                    feed_last;
  logic                    flush_last;
  logic                    row_last;
  logic [ROWS*DATA_WIDTH-1:0] a_feed;
  logic [COLS*DATA_WIDTH-1:0] w_feed;

  logic signed [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] w_v [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]  acc [ROWS][COLS];

  assign feed_last  = (cnt + 1'b1) == CW'(k_reg);
  assign flush_last = cnt == CW'(ROWS + COLS - 2);
  assign row_last   = row_idx == RW'(ROWS - 1);

  // Zero operands during FLUSH push the last skewed values through the array.
  assign a_feed = (state == FEED) ? a_vec_i : '0;
  assign w_feed = (state == FEED) ? w_vec_i : '0;

  always_comb begin
    next         = state;
    adv          = 1'b0;
    clr          = 1'b0;
    bias_add     = 1'b0;
    in_ready_o   = 1'b0;
    bias_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i) begin
          clr  = 1'b1;
          next = (k_len_i == '0) ? BIAS : FEED;
        end
      end
      FEED: begin
        in_ready_o = 1'b1;
        adv        = in_valid_i;
        if (in_valid_i && feed_last) next = FLUSH;
      end
      FLUSH: begin
        adv = 1'b1;
        if (flush_last) next = BIAS;
      end
      BIAS: begin
        bias_ready_o = 1'b1;
        if (bias_valid_i) begin
          bias_add = 1'b1;
          next     = DRAIN;
        end
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && row_last) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      row_idx   <= '0;
    end else begin
      state <= next;
      if (clr) begin
        k_reg     <= k_len_i;
        shift_reg <= shift_i;
        cnt       <= '0;
        row_idx   <= '0;
      end else if (state == FEED && in_valid_i) begin
        cnt <= feed_last ? '0 : cnt + 1'b1;
      end else if (state == FLUSH) begin
        cnt <= flush_last ? '0 : cnt + 1'b1;
      end
      if (state == DRAIN && out_ready_i) row_idx <= row_last ? '0 : row_idx + 1'b1;
    end
  end

  // Row r of A is delayed r advances before entering PE(r,0).
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_h[0][0] = a_feed[0 +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int unsigned i = 0; i < r; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= a_feed[r*DATA_WIDTH +: DATA_WIDTH];
          for (int unsigned i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_h[r][0] = sr[r-1];
    end
  end

  // Column c of W is delayed c advances before entering PE(0,c).
  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    if (c == 0) begin : g_direct
      assign w_v[0][0] = w_feed[0 +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int unsigned i = 0; i < c; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= w_feed[c*DATA_WIDTH +: DATA_WIDTH];
          for (int unsigned i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign w_v[0][c] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .clr      (clr),
        .bias_add (bias_add),
        .a_in     (a_h[r][c]),
        .w_in     (w_v[r][c]),
        .bias     (bias_vec_i[c*DATA_WIDTH +: DATA_WIDTH]),
        .a_out    (a_h[r][c+1]),
        .w_out    (w_v[r+1][c]),
        .acc      (acc[r][c])
      );
    end
  end

  always_comb begin
    wide_t q;
    q         = '0;
    out_row_o = '0;
    if (state == DRAIN) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        q = requant(64'(acc[row_idx][c]), 32'(shift_reg), DATA_WIDTH);
`ifdef SA_RELU_EN
        if (q < 0) q = '0;
`else
        q = q;
`endif
        out_row_o[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(q);
      end
    end
  end

  assign out_last_o = (state == DRAIN) && row_last;

endmodule
